// File: rtl/memory_stage_if.sv
// Execute-to-memory bundle plus memory-stage results toward write-back.
// Latency: none, this is wiring only.
// Backpressure: stall_i and bubble_i travel with the bundle as pipeline control.
interface memory_stage_if;
  // pipeline control
  logic        stall_i;
  logic        bubble_i;
  // execute-stage bundle
  logic [3:0]  icode_i;
  logic [2:0]  stat_i;
  logic [63:0] valE_i;
  logic [63:0] valA_i;
  logic [3:0]  dstE_i;
  logic [3:0]  dstM_i;
  logic        cnd_i;
  // results toward write-back
  logic [3:0]  icode_o;
  logic [2:0]  stat_o;
  logic [63:0] valE_o;
  logic [63:0] valM_o;
  logic [3:0]  dstE_o;
  logic [3:0]  dstM_o;
  logic        mem_err_o;

  modport master (
    output stall_i, bubble_i, icode_i, stat_i, valE_i, valA_i, dstE_i, dstM_i, cnd_i,
    input  icode_o, stat_o, valE_o, valM_o, dstE_o, dstM_o, mem_err_o
  );

  modport slave (
    input  stall_i, bubble_i, icode_i, stat_i, valE_i, valA_i, dstE_i, dstM_i, cnd_i,
    output icode_o, stat_o, valE_o, valM_o, dstE_o, dstM_o, mem_err_o
  );
endinterface

// File: rtl/memory_stage.sv
// Y86-64 memory stage: M pipeline register, byte-addressed data memory, cmov destination resolve.
// Latency: outputs valid combinationally after the capturing edge; a store commits on the next edge.
// Backpressure: stall_i holds the M register (stat STALL, no access); bubble_i injects a nop.
module memory_stage #(
  parameter int DEPTH_BYTES = 1024
) (
  input logic          clk_i,
  input logic          rst_n_i,
  memory_stage_if.slave bus
);
  localparam int AW = $clog2(DEPTH_BYTES);
  // Highest legal word address; comparing against this avoids computing addr+7.
  localparam logic [63:0] LAST_ADDR = 64'(DEPTH_BYTES - 8);

  localparam logic [2:0] STAT_RESET  = 3'd0;
  localparam logic [2:0] STAT_OK     = 3'd1;
  localparam logic [2:0] STAT_ADR    = 3'd2;
  localparam logic [2:0] STAT_BUBBLE = 3'd5;
  localparam logic [2:0] STAT_STALL  = 3'd6;

  localparam logic [3:0] ICMOVQ  = 4'h2;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] REG_NONE = 4'hf;

  logic [2:0]  stat_r;
  logic [3:0]  icode_r;
  logic [63:0] valE_r;
  logic [63:0] valA_r;
  logic [3:0]  dstE_r;
  logic [3:0]  dstM_r;

  logic [7:0]  mem [DEPTH_BYTES];

  logic        is_rd;
  logic        is_wr;
  logic [63:0] addr;
  logic        active;
  logic        in_range;
  logic        wr_en;
  logic [AW-1:0] base;
  logic [63:0] rd_word;

  // M pipeline register, priority reset > stall > bubble > load
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      stat_r  <= STAT_RESET;
      icode_r <= 4'h0;
      valE_r  <= 64'h0;
      valA_r  <= 64'h0;
      dstE_r  <= REG_NONE;
      dstM_r  <= REG_NONE;
    end else if (bus.stall_i) begin
      stat_r  <= STAT_STALL;
    end else if (bus.bubble_i) begin
      stat_r  <= STAT_BUBBLE;
      icode_r <= 4'h0;
      valE_r  <= 64'h0;
      valA_r  <= 64'h0;
      dstE_r  <= REG_NONE;
      dstM_r  <= REG_NONE;
    end else begin
      stat_r  <= bus.stat_i;
      icode_r <= bus.icode_i;
      valE_r  <= bus.valE_i;
      valA_r  <= bus.valA_i;
      // a cmov whose condition failed writes no register
      dstE_r  <= (bus.icode_i == ICMOVQ && !bus.cnd_i) ? REG_NONE : bus.dstE_i;
      dstM_r  <= bus.dstM_i;
    end
  end

  // decode access kind and address from the registered instruction
  always_comb begin
    is_rd = 1'b0;
    is_wr = 1'b0;
    case (icode_r)
      IMRMOVQ, IPOPQ, IRET:   is_rd = 1'b1;
      IRMMOVQ, IPUSHQ, ICALL: is_wr = 1'b1;
      default: ;
    endcase
    addr = (icode_r == IPOPQ || icode_r == IRET) ? valA_r : valE_r;
  end

  assign active   = (stat_r == STAT_OK) && (is_rd || is_wr);
  assign in_range = (addr <= LAST_ADDR);
  assign base     = addr[AW-1:0];
  // reset at the commit edge also suppresses a pending store
  assign wr_en    = rst_n_i && active && is_wr && in_range;

  // gather the little-endian word starting at base
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 8; i++) begin
      rd_word[8*i +: 8] = mem[base + AW'(i)];
    end
  end

  // store valA_r little-endian; array is deliberately not reset
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        mem[base + AW'(i)] <= valA_r[8*i +: 8];
      end
    end
  end

  assign bus.valM_o    = (active && is_rd && in_range) ? rd_word : 64'h0;
  assign bus.mem_err_o = active && !in_range;
  assign bus.stat_o    = (active && !in_range) ? STAT_ADR : stat_r;
  assign bus.icode_o   = icode_r;
  assign bus.valE_o    = valE_r;
  assign bus.dstE_o    = dstE_r;
  assign bus.dstM_o    = dstM_r;
endmodule

// File: tb/tb_memory_stage.sv
// Testbench for memory_stage: directed scenarios then random traffic against a reference model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: stall/bubble/reset driven directly by the stimulus.
module tb_memory_stage;
  localparam int DEPTH = 1024;

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_OK     = 3'd1;
  localparam logic [2:0] S_ADR    = 3'd2;
  localparam logic [2:0] S_BUBBLE = 3'd5;
  localparam logic [2:0] S_STALL  = 3'd6;

  localparam logic [3:0] I_CMOVQ  = 4'h2;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hf;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  memory_stage_if bus();

  memory_stage #(.DEPTH_BYTES(DEPTH)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: the last instruction accepted plus a byte array
  logic [7:0]  ref_mem [DEPTH];
  logic [2:0]  m_stat;
  logic [3:0]  m_icode;
  logic [63:0] m_valE;
  logic [63:0] m_valA;
  logic [3:0]  m_dstE;
  logic [3:0]  m_dstM;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // what the held instruction does this cycle
  task automatic model_eval(output logic act_rd, output logic act_wr, output logic err,
                            output logic [63:0] a);
    logic rd, wr, ok;
    rd = m_icode inside {I_MRMOVQ, I_POPQ, I_RET};
    wr = m_icode inside {I_RMMOVQ, I_PUSHQ, I_CALL};
    a  = (m_icode inside {I_POPQ, I_RET}) ? m_valA : m_valE;
    ok = (a <= 64'(DEPTH - 8));
    act_rd = (m_stat == S_OK) && rd && ok;
    act_wr = (m_stat == S_OK) && wr && ok;
    err    = (m_stat == S_OK) && (rd || wr) && !ok;
  endtask

  task automatic check_outputs();
    logic ard, awr, er;
    logic [63:0] a, w;
    model_eval(ard, awr, er, a);
    w = 64'h0;
    if (ard) begin
      for (int i = 0; i < 8; i++) w = w | (64'(ref_mem[int'(a) + i]) << (8 * i));
    end
    chk("stat",    64'(bus.stat_o),    64'(er ? S_ADR : m_stat));
    chk("icode",   64'(bus.icode_o),   64'(m_icode));
    chk("valE",    bus.valE_o,         m_valE);
    chk("valM",    bus.valM_o,         w);
    chk("dstE",    64'(bus.dstE_o),    64'(m_dstE));
    chk("dstM",    64'(bus.dstM_o),    64'(m_dstM));
    chk("mem_err", 64'(bus.mem_err_o), 64'(er));
  endtask

  task automatic step(input logic rst, input logic stall, input logic bubble,
                      input logic [3:0] ic, input logic [2:0] st,
                      input logic [63:0] ve, input logic [63:0] va,
                      input logic [3:0] de, input logic [3:0] dm, input logic cnd);
    logic ard, awr, er;
    logic [63:0] a;
    rst_n        = rst;
    bus.stall_i  = stall;
    bus.bubble_i = bubble;
    bus.icode_i  = ic;
    bus.stat_i   = st;
    bus.valE_i   = ve;
    bus.valA_i   = va;
    bus.dstE_i   = de;
    bus.dstM_i   = dm;
    bus.cnd_i    = cnd;
    @(posedge clk);
    model_eval(ard, awr, er, a);
    if (rst && awr) begin
      for (int i = 0; i < 8; i++) ref_mem[int'(a) + i] = m_valA[8*i +: 8];
    end
    if (!rst || (!stall && bubble)) begin
      m_stat = rst ? S_BUBBLE : S_RESET;
      m_icode = 4'h0; m_valE = 64'h0; m_valA = 64'h0; m_dstE = R_NONE; m_dstM = R_NONE;
    end else if (stall) begin
      m_stat = S_STALL;
    end else begin
      m_stat = st; m_icode = ic; m_valE = ve; m_valA = va; m_dstM = dm;
      m_dstE = (ic == I_CMOVQ && !cnd) ? R_NONE : de;
    end
    #1;
    check_outputs();
  endtask

  task automatic ld(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va,
                    input logic [3:0] de, input logic [3:0] dm, input logic cnd);
    step(1'b1, 1'b0, 1'b0, ic, S_OK, ve, va, de, dm, cnd);
  endtask

  function automatic logic [63:0] rand_addr();
    case ($urandom_range(0, 3))
      0, 1:    return 64'($urandom_range(0, DEPTH - 8));
      2:       return 64'($urandom_range(DEPTH - 16, DEPTH + 8));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [7:0] saved;

    // reset, then reset-value checks
    step(1'b0, 1'b0, 1'b0, 4'h5, S_OK, 64'h10, 64'h10, 4'h1, 4'h1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 4'h5, S_OK, 64'h10, 64'h10, 4'h1, 4'h1, 1'b1);
    chk("rst_stat",  64'(bus.stat_o), 64'(S_RESET));
    chk("rst_dstE",  64'(bus.dstE_o), 64'hf);
    chk("rst_valM",  bus.valM_o, 64'h0);

    // fill memory so every byte is known to the model
    for (int a = 0; a < DEPTH; a += 8) ld(I_RMMOVQ, 64'(a), {$urandom, $urandom}, R_NONE, R_NONE, 1'b0);

    // store then load the same word
    ld(I_RMMOVQ, 64'h10, 64'h1122334455667788, R_NONE, R_NONE, 1'b0);
    ld(I_MRMOVQ, 64'h10, 64'h0, R_NONE, 4'd3, 1'b0);
    chk("ld_valM", bus.valM_o, 64'h1122334455667788);
    chk("ld_dstM", 64'(bus.dstM_o), 64'd3);
    chk("byte10",  64'(dut.mem[16]), 64'h88);

    // conditional move
    ld(I_CMOVQ, 64'h55, 64'h0, 4'd2, R_NONE, 1'b0);
    chk("cmov_nc_dstE", 64'(bus.dstE_o), 64'hf);
    chk("cmov_nc_valE", bus.valE_o, 64'h55);
    ld(I_CMOVQ, 64'h66, 64'h0, 4'd2, R_NONE, 1'b1);
    chk("cmov_c_dstE", 64'(bus.dstE_o), 64'd2);
    chk("cmov_c_valE", bus.valE_o, 64'h66);

    // range boundary
    ld(I_MRMOVQ, 64'h3F8, 64'h0, R_NONE, 4'd1, 1'b0);
    chk("bnd_ok_err", 64'(bus.mem_err_o), 64'd0);
    ld(I_MRMOVQ, 64'h3F9, 64'h0, R_NONE, 4'd1, 1'b0);
    chk("bnd_bad_err",  64'(bus.mem_err_o), 64'd1);
    chk("bnd_bad_stat", 64'(bus.stat_o), 64'(S_ADR));
    chk("bnd_bad_valM", bus.valM_o, 64'h0);
    ld(I_RMMOVQ, 64'hFFFFFFFFFFFFFFFC, 64'hDEADBEEFDEADBEEF, R_NONE, R_NONE, 1'b0);
    chk("wrap_err", 64'(bus.mem_err_o), 64'd1);
    ld(4'h1, 64'h0, 64'h0, R_NONE, R_NONE, 1'b0);
    chk("wrap_nowr", 64'(dut.mem[10'h3FC]), 64'(ref_mem[10'h3FC]));

    // popq reads through valA
    ld(I_RMMOVQ, 64'h20, 64'hABCD, R_NONE, R_NONE, 1'b0);
    ld(I_POPQ, 64'h28, 64'h20, 4'd4, 4'd5, 1'b1);
    chk("pop_valM", bus.valM_o, 64'hABCD);
    chk("pop_valE", bus.valE_o, 64'h28);

    // pushq held by stall for 3 cycles, then stall+bubble, then bubble
    ld(I_PUSHQ, 64'h200, 64'h0123456789ABCDEF, 4'd4, R_NONE, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 1'b0, I_MRMOVQ, S_OK, 64'h8, 64'h8, 4'd1, 4'd1, 1'b1);
      chk("stall_stat", 64'(bus.stat_o), 64'(S_STALL));
    end
    chk("push_data", 64'(dut.mem[10'h200]), 64'hEF);
    step(1'b1, 1'b1, 1'b1, I_MRMOVQ, S_OK, 64'h8, 64'h8, 4'd1, 4'd1, 1'b1);
    chk("stall_bub_stat", 64'(bus.stat_o), 64'(S_STALL));
    step(1'b1, 1'b0, 1'b1, I_MRMOVQ, S_OK, 64'h8, 64'h8, 4'd1, 4'd1, 1'b1);
    chk("bub_stat", 64'(bus.stat_o), 64'(S_BUBBLE));
    chk("bub_dstM", 64'(bus.dstM_o), 64'hf);

    // reset lands on the edge that would commit a store
    saved = ref_mem[64];
    ld(I_RMMOVQ, 64'h40, {8'h00, 48'h0, ~saved}, R_NONE, R_NONE, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'h0, S_OK, 64'h0, 64'h0, R_NONE, R_NONE, 1'b0);
    chk("rst_st_nowr", 64'(dut.mem[64]), 64'(saved));
    chk("rst_st_stat", 64'(bus.stat_o), 64'(S_RESET));
    chk("rst_st_icode", 64'(bus.icode_o), 64'h0);

    // random traffic
    for (int n = 0; n < 500; n++) begin
      step(($urandom_range(0, 49) != 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) == 0),
           4'($urandom_range(0, 11)),
           ($urandom_range(0, 3) != 0) ? S_OK : 3'($urandom_range(0, 7)),
           rand_addr(), rand_addr(),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)));
    end
    step(1'b1, 1'b0, 1'b1, 4'h0, S_OK, 64'h0, 64'h0, R_NONE, R_NONE, 1'b0);

    // final memory image
    for (int a = 0; a < DEPTH; a++) chk("mem_img", 64'(dut.mem[a]), 64'(ref_mem[a]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
